// File: rtl/write_burst_gen_pkg.sv
// Shared constants for write_burst_gen: FSM state encoding, 4 KiB page size, log2 helper.
package write_burst_gen_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ARMED = 2'd1;
   localparam logic [1:0] ST_ADDR  = 2'd2;
   localparam logic [1:0] ST_DATA  = 2'd3;

   localparam int unsigned C_4K = 4096;

   function automatic int c_log_2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction

endpackage

// File: rtl/write_burst_gen_fifo.sv
// Beat buffer for write_burst_gen: first-word-fall-through FIFO on an inferred RAM with a
// registered read port; o_fifo_count drives burst sizing upstream.
module write_burst_gen_fifo #(
   parameter int DATA_WIDTH = 160,
   parameter int ADDR_WIDTH = 5
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  i_push,
   input  logic [DATA_WIDTH-1:0] i_push_data,
   input  logic                  i_pop,
   output logic [DATA_WIDTH-1:0] o_head,
   output logic [ADDR_WIDTH:0]   o_fifo_count,
   output logic                  o_full,
   output logic                  o_drop
);
   localparam int DEPTH = 1 << ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];
   logic [DATA_WIDTH-1:0] r_head;
   logic [ADDR_WIDTH-1:0] r_wr_ptr;
   logic [ADDR_WIDTH-1:0] r_rd_ptr;
   logic [ADDR_WIDTH:0]   r_count;

   logic                  w_full;
   logic                  w_pop;
   logic                  w_push;
   logic [ADDR_WIDTH-1:0] w_rd_ptr_next;

   assign w_full        = (r_count == (ADDR_WIDTH+1)'(DEPTH));
   assign w_pop         = i_pop && (r_count != '0);
   assign w_push        = i_push && (!w_full || w_pop);
   assign w_rd_ptr_next = r_rd_ptr + ADDR_WIDTH'(w_pop);

   // Head register pre-reads the next entry; a write landing on that entry is bypassed.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_push_data;
      if (w_push && (r_wr_ptr == w_rd_ptr_next)) r_head <= i_push_data;
      else                                       r_head <= r_mem[w_rd_ptr_next];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         r_rd_ptr <= w_rd_ptr_next;
         r_count  <= r_count + (ADDR_WIDTH+1)'(w_push) - (ADDR_WIDTH+1)'(w_pop);
      end
   end

   assign o_head       = r_head;
   assign o_fifo_count = r_count;
   assign o_full       = w_full;
   assign o_drop       = i_push && w_full && !w_pop;

endmodule

// File: rtl/write_burst_gen.sv
// Buffers serdes output beats and issues address/data write bursts from a base address.
// Optional WBG_4K_SPLIT_EN: bursts are trimmed so they never cross a 4 KiB boundary.
module write_burst_gen
   import write_burst_gen_pkg::*;
#(
   parameter int DATA_W    = 160,
   parameter int ADDR_W    = 32,
   parameter int ADDR_INC  = 32,
   parameter int BURST_LEN = 16,
   parameter int FIFO_AW   = 5,
   parameter int NUM_W     = 20
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cfg_start,
   input  logic [ADDR_W-1:0] cfg_base_addr,
   input  logic [NUM_W-1:0]  cfg_num_beats,
   input  logic              s_flush,
   input  logic              s_write_req,
   input  logic [DATA_W-1:0] s_write_data,
   output logic              s_write_ready,
   output logic              m_awvalid,
   input  logic              m_awready,
   output logic [ADDR_W-1:0] m_awaddr,
   output logic [7:0]        m_awlen,
   output logic              m_wvalid,
   input  logic              m_wready,
   output logic [DATA_W-1:0] m_wdata,
   output logic              m_wlast,
   output logic              done,
   output logic              busy,
   output logic              overflow
);
   localparam int LEN_W = c_log_2(BURST_LEN) + 1;

   logic [1:0]        r_state;
   logic [ADDR_W-1:0] r_addr;
   logic [NUM_W-1:0]  r_rem;
   logic [LEN_W-1:0]  r_blen;
   logic [LEN_W-1:0]  r_sent;
   logic              r_awvalid;
   logic [ADDR_W-1:0] r_awaddr;
   logic [7:0]        r_awlen;
   logic              r_wvalid;
   logic [DATA_W-1:0] r_wdata;
   logic              r_wlast;
   logic              r_done;
   logic              r_overflow;
   logic              r_flush;

   logic [DATA_W-1:0] w_head;
   logic [FIFO_AW:0]  w_fifo_count;
   logic              w_full;
   logic              w_drop;
   logic              w_load;
   logic [NUM_W-1:0]  w_cnt;
   logic [NUM_W-1:0]  w_cap;
   logic [NUM_W-1:0]  w_blen;
   logic              w_full_burst;
   logic              w_go;
   logic              w_start;
`ifdef WBG_4K_SPLIT_EN
   logic [12:0]       w_room;
   logic [NUM_W-1:0]  w_lim;
`endif

   write_burst_gen_fifo #(
      .DATA_WIDTH (DATA_W),
      .ADDR_WIDTH (FIFO_AW)
   ) u_fifo (
      .clk          (clk),
      .reset        (reset),
      .i_push       (s_write_req),
      .i_push_data  (s_write_data),
      .i_pop        (w_load),
      .o_head       (w_head),
      .o_fifo_count (w_fifo_count),
      .o_full       (w_full),
      .o_drop       (w_drop)
   );

   // Output prefetch: refill the W register whenever it is empty or being consumed.
   assign w_load  = (r_state == ST_DATA) && (!r_wvalid || m_wready) &&
                    (r_sent != r_blen) && (w_fifo_count != '0);
   assign w_start = cfg_start && (r_state == ST_IDLE);
   assign w_cnt   = NUM_W'(w_fifo_count);

   always_comb begin
      w_cap = (r_rem < NUM_W'(BURST_LEN)) ? r_rem : NUM_W'(BURST_LEN);
`ifdef WBG_4K_SPLIT_EN
      w_room = 13'(C_4K) - {1'b0, r_addr[11:0]};
      w_lim  = NUM_W'(w_room / 13'(ADDR_INC));
      if (w_lim < w_cap) w_cap = w_lim;
`endif
      w_full_burst = (w_cnt >= w_cap);
      w_go         = w_full_burst || (r_flush && (w_cnt != '0));
      w_blen       = w_full_burst ? w_cap : w_cnt;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= ST_IDLE;
         r_addr     <= '0;
         r_rem      <= '0;
         r_blen     <= '0;
         r_sent     <= '0;
         r_awvalid  <= 1'b0;
         r_awaddr   <= '0;
         r_awlen    <= '0;
         r_wvalid   <= 1'b0;
         r_wdata    <= '0;
         r_wlast    <= 1'b0;
         r_done     <= 1'b0;
         r_overflow <= 1'b0;
         r_flush    <= 1'b0;
      end else begin
         r_done <= 1'b0;

         if (w_drop)       r_overflow <= 1'b1;
         else if (w_start) r_overflow <= 1'b0;

         if (s_flush) r_flush <= 1'b1;
         else if (w_start || ((r_state == ST_ARMED) && (w_fifo_count == '0))) r_flush <= 1'b0;

         case (r_state)
            ST_IDLE: begin
               if (cfg_start) begin
                  r_addr <= cfg_base_addr;
                  r_rem  <= cfg_num_beats;
                  if (cfg_num_beats == '0) r_done  <= 1'b1;
                  else                     r_state <= ST_ARMED;
               end
            end
            ST_ARMED: begin
               if (w_go) begin
                  r_awvalid <= 1'b1;
                  r_awaddr  <= r_addr;
                  r_awlen   <= 8'(w_blen - 1'b1);
                  r_blen    <= LEN_W'(w_blen);
                  r_state   <= ST_ADDR;
               end
            end
            ST_ADDR: begin
               if (m_awready) begin
                  r_awvalid <= 1'b0;
                  r_addr    <= r_addr + ADDR_W'(r_blen) * ADDR_W'(ADDR_INC);
                  r_rem     <= r_rem - NUM_W'(r_blen);
                  r_sent    <= '0;
                  r_state   <= ST_DATA;
               end
            end
            default: begin
               if (w_load) begin
                  r_wvalid <= 1'b1;
                  r_wdata  <= w_head;
                  r_wlast  <= (r_sent == r_blen - 1'b1);
                  r_sent   <= r_sent + 1'b1;
               end else if (m_wready) begin
                  r_wvalid <= 1'b0;
                  r_wlast  <= 1'b0;
               end
               if (r_wvalid && m_wready && r_wlast) begin
                  r_state <= (r_rem == '0) ? ST_IDLE : ST_ARMED;
                  r_done  <= (r_rem == '0);
               end
            end
         endcase
      end
   end

   assign s_write_ready = !w_full;
   assign m_awvalid     = r_awvalid;
   assign m_awaddr      = r_awaddr;
   assign m_awlen       = r_awlen;
   assign m_wvalid      = r_wvalid;
   assign m_wdata       = r_wdata;
   assign m_wlast       = r_wlast;
   assign done          = r_done;
   assign busy          = (r_state != ST_IDLE);
   assign overflow      = r_overflow;

endmodule

// File: tb/tb_write_burst_gen.sv
// Self-checking bench for write_burst_gen with random beat data and a burst-splitting model.
// Define WBG_4K_SPLIT_EN to also exercise the 4 KiB boundary split.
module tb_write_burst_gen;
   logic          clk = 1'b0;
   logic          reset;
   logic          cfg_start;
   logic [31:0]   cfg_base_addr;
   logic [19:0]   cfg_num_beats;
   logic          s_flush;
   logic          s_write_req;
   logic [159:0]  s_write_data;
   logic          s_write_ready;
   logic          m_awvalid;
   logic          m_awready;
   logic [31:0]   m_awaddr;
   logic [7:0]    m_awlen;
   logic          m_wvalid;
   logic          m_wready;
   logic [159:0]  m_wdata;
   logic          m_wlast;
   logic          done;
   logic          busy;
   logic          overflow;

   logic wready_fix, wready_rnd, wready_rand_en;
   assign m_wready = wready_rand_en ? wready_rnd : wready_fix;

   int n_checks = 0;
   int n_pass   = 0;

   write_burst_gen dut (
      .clk(clk), .reset(reset), .cfg_start(cfg_start), .cfg_base_addr(cfg_base_addr),
      .cfg_num_beats(cfg_num_beats), .s_flush(s_flush), .s_write_req(s_write_req),
      .s_write_data(s_write_data), .s_write_ready(s_write_ready), .m_awvalid(m_awvalid),
      .m_awready(m_awready), .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_wvalid(m_wvalid),
      .m_wready(m_wready), .m_wdata(m_wdata), .m_wlast(m_wlast), .done(done), .busy(busy),
      .overflow(overflow)
   );

   always #5 clk = ~clk;
   always @(posedge clk) wready_rnd <= 1'($urandom_range(0, 1));

   // Bus monitor: logs handshakes, counts done pulses and W stability violations.
   logic [31:0]  aw_addr_log [0:1023];
   int           aw_len_log  [0:1023];
   logic [159:0] w_data_log  [0:1023];
   logic         w_last_log  [0:1023];
   int aw_cnt = 0, w_cnt = 0, done_cnt = 0, stall_viol = 0;
   logic         prev_stall = 1'b0;
   logic [159:0] held_data;
   logic         held_last;

   always @(negedge clk) begin
      if (reset) begin
         prev_stall <= 1'b0;
      end else begin
         if (m_awvalid && m_awready && aw_cnt < 1024) begin
            aw_addr_log[aw_cnt] <= m_awaddr;
            aw_len_log[aw_cnt]  <= int'(m_awlen) + 1;
            aw_cnt              <= aw_cnt + 1;
            $display("AW  addr=0x%08h awlen=%0d", m_awaddr, m_awlen);
         end
         if (m_wvalid && m_wready && w_cnt < 1024) begin
            w_data_log[w_cnt] <= m_wdata;
            w_last_log[w_cnt] <= m_wlast;
            w_cnt             <= w_cnt + 1;
         end
         if (prev_stall && (!m_wvalid || m_wdata !== held_data || m_wlast !== held_last))
            stall_viol <= stall_viol + 1;
         prev_stall <= m_wvalid && !m_wready;
         held_data  <= m_wdata;
         held_last  <= m_wlast;
         if (done) done_cnt <= done_cnt + 1;
      end
   end

   // Reference model: expected bursts and per-beat wlast from base/num alone.
   logic [31:0]  exp_addr [0:63];
   int           exp_len  [0:63];
   logic         exp_last [0:1023];
   int           exp_cnt;
   logic [159:0] exp_q [$];

   task automatic build_model(input logic [31:0] base, input int num);
      logic [31:0] a;
      int rem, b, k;
      a = base; rem = num; exp_cnt = 0; k = 0;
      while (rem > 0) begin
         b = (rem < 16) ? rem : 16;
`ifdef WBG_4K_SPLIT_EN
         if ((4096 - int'(a % 4096)) / 32 < b) b = (4096 - int'(a % 4096)) / 32;
`endif
         exp_addr[exp_cnt] = a;
         exp_len[exp_cnt]  = b;
         exp_cnt++;
         for (int i = 0; i < b; i++) begin
            exp_last[k] = (i == b - 1);
            k++;
         end
         a   = a + 32'(b * 32);
         rem = rem - b;
      end
   endtask

   function automatic logic [159:0] rand_beat();
      return {$urandom, $urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      cfg_start = 1'b0; s_flush = 1'b0; s_write_req = 1'b0;
      tick(); tick();
      reset = 1'b0;
   endtask

   task automatic push_beat(input bit keep);
      logic [159:0] d;
      d = rand_beat();
      s_write_req = 1'b1;
      s_write_data = d;
      if (keep) exp_q.push_back(d);
      tick();
      s_write_req = 1'b0;
   endtask

   task automatic start_cfg(input logic [31:0] base, input int num);
      cfg_base_addr = base;
      cfg_num_beats = 20'(num);
      cfg_start = 1'b1;
      tick();
      cfg_start = 1'b0;
   endtask

   task automatic wait_done(input int base_cnt, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (done_cnt > base_cnt) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
   endtask

   task automatic test_reset();
      // Get a burst stuck mid-flight, then reset it away.
      do_reset();
      m_awready = 1'b1; wready_fix = 1'b0; wready_rand_en = 1'b0;
      start_cfg(32'h0000_8000, 16);
      for (int i = 0; i < 16; i++) push_beat(1'b0);
      tick(); tick();
      reset = 1'b1;
      tick();
      n_checks++;
      if ({m_awvalid, m_wvalid, m_wlast, done, busy, overflow, s_write_ready} !== 7'b0000001)
         $display("FAIL reset_flags got=%b want=0000001",
                  {m_awvalid, m_wvalid, m_wlast, done, busy, overflow, s_write_ready});
      else n_pass++;
      n_checks++;
      if (m_awaddr !== 32'h0 || m_awlen !== 8'h0 || m_wdata !== 160'h0)
         $display("FAIL reset_regs awaddr=%h awlen=%h wdata_nonzero=%b want 0",
                  m_awaddr, m_awlen, |m_wdata);
      else n_pass++;
      reset = 1'b0;
      wready_fix = 1'b1;
      tick(); tick(); tick();
      n_checks++;
      if (busy !== 1'b0 || m_awvalid !== 1'b0)
         $display("FAIL reset_quiet busy=%b awvalid=%b want 0 0", busy, m_awvalid);
      else n_pass++;
   endtask

   task automatic test_two_bursts();
      int ab, wb, db;
      bit ok;
      do_reset();
      m_awready = 1'b1; wready_fix = 1'b1; wready_rand_en = 1'b0;
      ab = aw_cnt; wb = w_cnt; db = done_cnt; exp_q.delete();
      build_model(32'h1000, 32);
      start_cfg(32'h1000, 32);
      for (int i = 0; i < 32; i++) push_beat(1'b1);
      wait_done(db, 300, ok);
      tick(); tick(); tick();
      n_checks++;
      if (!ok || aw_cnt - ab != exp_cnt)
         $display("FAIL two_bursts_count done=%b bursts=%0d want %0d", ok, aw_cnt - ab, exp_cnt);
      else n_pass++;
      for (int i = 0; i < exp_cnt && ab + i < aw_cnt; i++) begin
         n_checks++;
         if (aw_addr_log[ab+i] !== exp_addr[i] || aw_len_log[ab+i] != exp_len[i])
            $display("FAIL two_bursts_aw%0d got=%h/%0d want=%h/%0d", i,
                     aw_addr_log[ab+i], aw_len_log[ab+i], exp_addr[i], exp_len[i]);
         else n_pass++;
      end
      for (int i = 0; i < 32; i++) begin
         n_checks++;
         if (wb + i >= w_cnt || w_data_log[wb+i] !== exp_q[i] || w_last_log[wb+i] !== exp_last[i])
            $display("FAIL two_bursts_beat%0d got=%h/%b want=%h/%b", i,
                     w_data_log[wb+i], w_last_log[wb+i], exp_q[i], exp_last[i]);
         else n_pass++;
      end
      n_checks++;
      if (done_cnt - db != 1 || busy !== 1'b0)
         $display("FAIL two_bursts_done pulses=%0d busy=%b want 1 0", done_cnt - db, busy);
      else n_pass++;
   endtask

   task automatic test_partial();
      int ab, wb, db;
      bit ok;
      do_reset();
      m_awready = 1'b1; wready_fix = 1'b1; wready_rand_en = 1'b0;
      ab = aw_cnt; wb = w_cnt; db = done_cnt; exp_q.delete();
      build_model(32'h1000, 20);
      start_cfg(32'h1000, 20);
      for (int i = 0; i < 20; i++) push_beat(1'b1);
      wait_done(db, 300, ok);
      tick(); tick();
      n_checks++;
      if (!ok || aw_cnt - ab != exp_cnt || w_cnt - wb != 20)
         $display("FAIL partial_count done=%b bursts=%0d beats=%0d want %0d 20",
                  ok, aw_cnt - ab, w_cnt - wb, exp_cnt);
      else n_pass++;
      for (int i = 0; i < exp_cnt && ab + i < aw_cnt; i++) begin
         n_checks++;
         if (aw_addr_log[ab+i] !== exp_addr[i] || aw_len_log[ab+i] != exp_len[i])
            $display("FAIL partial_aw%0d got=%h/%0d want=%h/%0d", i,
                     aw_addr_log[ab+i], aw_len_log[ab+i], exp_addr[i], exp_len[i]);
         else n_pass++;
      end
      for (int i = 0; i < 20 && wb + i < w_cnt; i++) begin
         n_checks++;
         if (w_data_log[wb+i] !== exp_q[i] || w_last_log[wb+i] !== exp_last[i])
            $display("FAIL partial_beat%0d got=%h/%b want=%h/%b", i,
                     w_data_log[wb+i], w_last_log[wb+i], exp_q[i], exp_last[i]);
         else n_pass++;
      end
      n_checks++;
      if (done_cnt - db != 1)
         $display("FAIL partial_done pulses=%0d want 1", done_cnt - db);
      else n_pass++;
   endtask

   task automatic test_zero_beats();
      int ab, db;
      do_reset();
      ab = aw_cnt; db = done_cnt;
      cfg_base_addr = 32'h5000; cfg_num_beats = '0; cfg_start = 1'b1;
      tick();
      cfg_start = 1'b0;
      n_checks++;
      if (done !== 1'b1 || busy !== 1'b0)
         $display("FAIL zero_done_pulse done=%b busy=%b want 1 0", done, busy);
      else n_pass++;
      tick();
      n_checks++;
      if (done !== 1'b0) $display("FAIL zero_done_width done=%b want 0", done);
      else n_pass++;
      tick(); tick(); tick();
      n_checks++;
      if (aw_cnt != ab || done_cnt - db != 1)
         $display("FAIL zero_quiet bursts=%0d pulses=%0d want 0 1", aw_cnt - ab, done_cnt - db);
      else n_pass++;
   endtask

   task automatic test_flush();
      int ab, wb, db;
      do_reset();
      m_awready = 1'b1; wready_fix = 1'b1; wready_rand_en = 1'b0;
      ab = aw_cnt; wb = w_cnt; db = done_cnt; exp_q.delete();
      start_cfg(32'h2000, 100);
      for (int i = 0; i < 5; i++) push_beat(1'b1);
      tick(); tick(); tick();
      n_checks++;
      if (aw_cnt != ab) $display("FAIL flush_early bursts=%0d want 0", aw_cnt - ab);
      else n_pass++;
      s_flush = 1'b1;
      tick();
      s_flush = 1'b0;
      repeat (30) tick();
      n_checks++;
      if (aw_cnt - ab != 1 || aw_addr_log[ab] !== 32'h2000 || aw_len_log[ab] != 5)
         $display("FAIL flush_aw bursts=%0d addr=%h len=%0d want 1 00002000 5",
                  aw_cnt - ab, aw_addr_log[ab], aw_len_log[ab]);
      else n_pass++;
      for (int i = 0; i < 5; i++) begin
         n_checks++;
         if (wb + i >= w_cnt || w_data_log[wb+i] !== exp_q[i] || w_last_log[wb+i] !== (i == 4))
            $display("FAIL flush_beat%0d got=%h/%b want=%h/%b", i,
                     w_data_log[wb+i], w_last_log[wb+i], exp_q[i], (i == 4));
         else n_pass++;
      end
      n_checks++;
      if (busy !== 1'b1 || done_cnt != db || w_cnt - wb != 5)
         $display("FAIL flush_state busy=%b pulses=%0d beats=%0d want 1 0 5",
                  busy, done_cnt - db, w_cnt - wb);
      else n_pass++;
   endtask

   task automatic test_overflow();
      int ab, wb, db;
      bit ok;
      do_reset();
      m_awready = 1'b0; wready_fix = 1'b1; wready_rand_en = 1'b0;
      ab = aw_cnt; wb = w_cnt; db = done_cnt; exp_q.delete();
      for (int i = 0; i < 33; i++) push_beat(exp_q.size() < 32);
      n_checks++;
      if (overflow !== 1'b1 || s_write_ready !== 1'b0)
         $display("FAIL overflow_set overflow=%b ready=%b want 1 0", overflow, s_write_ready);
      else n_pass++;
      build_model(32'h3000, 32);
      start_cfg(32'h3000, 32);
      n_checks++;
      if (overflow !== 1'b0) $display("FAIL overflow_clear overflow=%b want 0", overflow);
      else n_pass++;
      m_awready = 1'b1;
      wait_done(db, 300, ok);
      repeat (5) tick();
      n_checks++;
      if (!ok || aw_cnt - ab != exp_cnt || w_cnt - wb != 32)
         $display("FAIL overflow_drain done=%b bursts=%0d beats=%0d want %0d 32",
                  ok, aw_cnt - ab, w_cnt - wb, exp_cnt);
      else n_pass++;
      for (int i = 0; i < 32 && wb + i < w_cnt; i++) begin
         n_checks++;
         if (w_data_log[wb+i] !== exp_q[i] || w_last_log[wb+i] !== exp_last[i])
            $display("FAIL overflow_beat%0d got=%h/%b want=%h/%b", i,
                     w_data_log[wb+i], w_last_log[wb+i], exp_q[i], exp_last[i]);
         else n_pass++;
      end
   endtask

   task automatic test_back_to_back_stall();
      int ab, wb, db, sv, guard;
      bit ok;
      do_reset();
      m_awready = 1'b1; wready_rand_en = 1'b1;
      ab = aw_cnt; wb = w_cnt; db = done_cnt; sv = stall_viol; exp_q.delete();
      build_model(32'h4000, 40);
      start_cfg(32'h4000, 40);
      for (int i = 0; i < 40; i++) begin
         guard = 0;
         while (!s_write_ready && guard < 500) begin
            tick();
            guard++;
         end
         push_beat(1'b1);
      end
      wait_done(db, 2000, ok);
      tick(); tick();
      wready_rand_en = 1'b0;
      n_checks++;
      if (!ok || aw_cnt - ab != exp_cnt || w_cnt - wb != 40)
         $display("FAIL stall_count done=%b bursts=%0d beats=%0d want %0d 40",
                  ok, aw_cnt - ab, w_cnt - wb, exp_cnt);
      else n_pass++;
      for (int i = 0; i < exp_cnt && ab + i < aw_cnt; i++) begin
         n_checks++;
         if (aw_addr_log[ab+i] !== exp_addr[i] || aw_len_log[ab+i] != exp_len[i])
            $display("FAIL stall_aw%0d got=%h/%0d want=%h/%0d", i,
                     aw_addr_log[ab+i], aw_len_log[ab+i], exp_addr[i], exp_len[i]);
         else n_pass++;
      end
      for (int i = 0; i < 40 && wb + i < w_cnt; i++) begin
         n_checks++;
         if (w_data_log[wb+i] !== exp_q[i] || w_last_log[wb+i] !== exp_last[i])
            $display("FAIL stall_beat%0d got=%h/%b want=%h/%b", i,
                     w_data_log[wb+i], w_last_log[wb+i], exp_q[i], exp_last[i]);
         else n_pass++;
      end
      n_checks++;
      if (stall_viol != sv || overflow !== 1'b0)
         $display("FAIL stall_stable violations=%0d overflow=%b want 0 0", stall_viol - sv, overflow);
      else n_pass++;
   endtask

`ifdef WBG_4K_SPLIT_EN
   task automatic test_4k_split();
      int ab, wb, db;
      bit ok;
      do_reset();
      m_awready = 1'b1; wready_fix = 1'b1; wready_rand_en = 1'b0;
      ab = aw_cnt; wb = w_cnt; db = done_cnt; exp_q.delete();
      start_cfg(32'h0F80, 16);
      for (int i = 0; i < 16; i++) push_beat(1'b1);
      wait_done(db, 300, ok);
      tick();
      n_checks++;
      if (!ok || aw_cnt - ab != 2) $display("FAIL split_count done=%b bursts=%0d want 2", ok, aw_cnt - ab);
      else n_pass++;
      n_checks++;
      if (aw_addr_log[ab] !== 32'h0F80 || aw_len_log[ab] != 4)
         $display("FAIL split_aw0 got=%h/%0d want=00000f80/4", aw_addr_log[ab], aw_len_log[ab]);
      else n_pass++;
      n_checks++;
      if (aw_addr_log[ab+1] !== 32'h1000 || aw_len_log[ab+1] != 12)
         $display("FAIL split_aw1 got=%h/%0d want=00001000/12", aw_addr_log[ab+1], aw_len_log[ab+1]);
      else n_pass++;
      for (int i = 0; i < 16; i++) begin
         n_checks++;
         if (wb + i >= w_cnt || w_data_log[wb+i] !== exp_q[i] || w_last_log[wb+i] !== (i == 3 || i == 15))
            $display("FAIL split_beat%0d got=%h/%b", i, w_data_log[wb+i], w_last_log[wb+i]);
         else n_pass++;
      end
   endtask
`endif

   initial begin
      reset = 1'b1;
      cfg_start = 1'b0; cfg_base_addr = '0; cfg_num_beats = '0;
      s_flush = 1'b0; s_write_req = 1'b0; s_write_data = '0;
      m_awready = 1'b0; wready_fix = 1'b0; wready_rand_en = 1'b0;
      test_reset();
      test_two_bursts();
      test_partial();
      test_zero_beats();
      test_flush();
      test_overflow();
      test_back_to_back_stall();
`ifdef WBG_4K_SPLIT_EN
      test_4k_split();
`endif
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/write_burst_gen.md
# write_burst_gen

Write-burst generator that sits directly downstream of the serdes stage in the dnnweaver output path. It absorbs the packed output words that serdes pushes out, which carry no backpressure. It buffers them, then issues address/data write bursts to the memory interface, starting at a configured base address, until a configured number of beats has been written. It reports completion and sticky overflow status to the layer controller.

## Interface
- DATA_W, 160, beat width; equals serdes OUT_COUNT*OP_WIDTH
- ADDR_W, 32, byte-address width
- ADDR_INC, 32, byte-address increment per beat
- BURST_LEN, 16, maximum beats per burst (power of two, ≤ 2^FIFO_AW)
- FIFO_AW, 5, log2 of buffer depth
- NUM_W, 20, width of the beat-count configuration
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- cfg_start  in  1  one-cycle pulse; latches cfg_base_addr and cfg_num_beats, clears status
- cfg_base_addr  in  ADDR_W  first beat address
- cfg_num_beats  in  NUM_W  total beats for this layer (0 = complete immediately)
- s_flush  in  1  end of the serdes stream; permits a partial burst
- s_write_req  in  1  beat push from serdes
- s_write_data  in  DATA_W  beat data
- s_write_ready  out  1  !buffer full (advisory; serdes ignores it)
- m_awvalid / m_awready  out / in  1  burst address handshake
- m_awaddr  out  ADDR_W  burst start address
- m_awlen  out  8  beats-1
- m_wvalid / m_wready  out / in  1  beat handshake
- m_wdata  out  DATA_W  beat data
- m_wlast  out  1  final beat of a burst
- done  out  1  one-cycle pulse when the last beat of cfg_num_beats is accepted
- busy  out  1  armed and beats remaining
- overflow  out  1  sticky: a push arrived while the buffer was full

## Operation
- States: IDLE, ARMED, ADDR, DATA.
- IDLE → ARMED on cfg_start. Latch addr=cfg_base_addr and rem=cfg_num_beats. If cfg_num_beats==0, pulse done and stay IDLE.
- ARMED → ADDR when one of the following holds, with blen as given:
  - buffer count ≥ min(BURST_LEN, rem): blen = min(BURST_LEN, rem).
  - flush_sticky && count>0: blen = min(count, rem).
- ADDR: hold m_awvalid, m_awaddr=addr, m_awlen=blen-1 stable until m_awready. On the handshake go to DATA, with addr += blen*ADDR_INC and rem -= blen.
- DATA: pop one buffered beat per m_wvalid&&m_wready. m_wlast is high on beat blen. After the wlast handshake:
  - if rem==0: pulse done and go to IDLE;
  - otherwise go to ARMED.
- flush_sticky is set by s_flush and cleared on cfg_start or when the buffer empties in ARMED.
- Pushes are accepted in every state, including IDLE. A push while full is dropped and sets overflow. Simultaneous push and pop when full is accepted (no overflow).
- Beats pushed beyond rem remain buffered for the next cfg_start. They are not discarded.
- cfg_start while busy is ignored.

## Timing
- Reset values:
  - state IDLE; m_awvalid=0, m_wvalid=0, m_wlast=0, done=0, busy=0, overflow=0;
  - m_awaddr=0, m_awlen=0, m_wdata=0; buffer empty; s_write_ready=1.
- Push to buffer-count visible: 1 cycle.
- ARMED → m_awvalid high: the cycle after the condition is true.
- First m_wvalid: ≤2 cycles after the AW handshake.
- Sustained throughput: one beat per cycle while m_wready=1. m_wvalid may not drop mid-burst.
- m_wdata and m_wlast must stay stable while m_wvalid && !m_wready.
- done is registered and asserts the cycle after the final W handshake.
- A reset mid-burst abandons the burst immediately. There is no attempt to complete the bus transaction.

## Configuration
- WBG_4K_SPLIT_EN:
  - Defined: blen is further limited so a burst never crosses a 4 KiB address boundary, i.e. blen ≤ (4096 - addr[11:0])/ADDR_INC. ADDR_INC must then divide 4096.
  - Undefined: no boundary check; bursts are sized only by BURST_LEN, rem, count and flush.

## Structure
- Shared package/header (common.vh): the state encoding localparams, the C_LOG_2 macro, and the 4 KiB constant.
- One sub-module: the existing `fifo` (DATA_WIDTH=DATA_W, ADDR_WIDTH=FIFO_AW). Use its fifo_count for burst sizing.
- An output prefetch register in this block provides zero-bubble beats.

## Test plan
- Configure base=0x1000, num_beats=32, BURST_LEN=16; push 32 beats back-to-back with m_ready=1. Expect two bursts: awaddr 0x1000 then 0x1200, both awlen=15, wlast on beats 16 and 32, done pulse once.
- num_beats=20: push 20 beats. Expect bursts of 16 then 4 (awlen=3 at 0x1200), then done.
- Push 5 beats, pulse s_flush, num_beats=100. Expect one burst awlen=4. busy stays 1 and done is not asserted.
- Push 33 beats with m_awready=0 and FIFO_AW=5. Expect overflow=1 and exactly 32 beats retained. cfg_start clears overflow.
- Toggle m_wready randomly 50% during a burst. Expect m_wdata/m_wlast stable while stalled and data order preserved.
- With WBG_4K_SPLIT_EN, base=0x0F80, ADDR_INC=32, num_beats=16. Expect bursts awlen=3 at 0x0F80, then awlen=11 at 0x1000.
